// File: rtl/joy_pkg.sv
// Shared types for the joystick sampler: direction word, ADC channel ids, FSM states.
package joy_pkg;

    typedef struct packed {
        logic fwd;
        logic back;
        logic left;
        logic right;
    } dir_t;

    localparam logic [4:0] JOY_CH_Y = 5'd1;
    localparam logic [4:0] JOY_CH_X = 5'd2;

    typedef enum logic [2:0] {
        IDLE,
        REQ_Y,
        WAIT_Y,
        REQ_X,
        WAIT_X,
        PUBLISH
    } joy_state_e;

    // Clamp a signed threshold computation into the 12-bit ADC range.
    function automatic logic [11:0] sat12(input int v);
        if (v < 0)
            return 12'd0;
        if (v > 4095)
            return 12'd4095;
        return v[11:0];
    endfunction

endpackage

// File: rtl/joy_axis_filter.sv
// One stick axis: sample accumulator, truncating average and hysteresis flags.
// hi_o is fwd/left, lo_o is back/right; hi wins if both would be set.
module joy_axis_filter #(
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        add_i,
    input  logic        last_i,
    input  logic        tmo_i,
    input  logic        mute_i,
    input  logic [11:0] data_i,
    input  logic [11:0] hi_thr_i,
    input  logic [11:0] lo_thr_i,
    output logic [11:0] avg_o,
    output logic        hi_o,
    output logic        lo_o
);

    localparam int AW = 12 + AVG_LOG2;

    logic [AW-1:0]      acc_q, acc_d;
    logic [11:0]        avg_q, avg_d;
    logic               hi_q, hi_d, lo_q, lo_d;
    logic signed [14:0] a_s, hi_s, lo_s;

    always_comb begin
        acc_d = acc_q + AW'(data_i);
        avg_d = acc_d[AW-1:AVG_LOG2];
        a_s   = $signed({3'b000, avg_d});
        hi_s  = $signed({3'b000, hi_thr_i});
        lo_s  = $signed({3'b000, lo_thr_i});
        // An asserted flag only drops once the average is HYST back inside its threshold.
        hi_d  = hi_q ? !(a_s < hi_s - 15'(HYST)) : (a_s > hi_s);
        lo_d  = lo_q ? !(a_s > lo_s + 15'(HYST)) : (a_s < lo_s);
        if (hi_d && lo_d)
            lo_d = 1'b0;
        if (mute_i) begin
            hi_d = 1'b0;
            lo_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            avg_q <= '0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            if (last_i) begin
                acc_q <= '0;
                avg_q <= avg_d;
                hi_q  <= hi_d;
                lo_q  <= lo_d;
            end else begin
                acc_q <= acc_d;
            end
        end else if (tmo_i) begin
            acc_q <= '0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
        end
    end

    assign avg_o = avg_q;
    assign hi_o  = hi_q;
    assign lo_o  = lo_q;

endmodule

// File: rtl/joystick_sampler.sv
// Frame-aligned joystick sampler: drives the ADC command/response stream, averages Y/X and
// publishes a direction word over valid/ready. JOY_CENTER_CAL_EN enables center calibration.
module joystick_sampler
    import joy_pkg::*;
#(
    parameter int AVG_LOG2  = 2,
    parameter int HI_THRESH = 2000,
    parameter int LO_THRESH = 700,
    parameter int HYST      = 64,
    parameter int TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_frame,
    output logic        cmd_valid,
    output logic [4:0]  cmd_channel,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [4:0]  rsp_channel,
    input  logic [11:0] rsp_data,
    output logic        dir_valid,
    input  logic        dir_ready,
    output logic        move_fwd,
    output logic        move_back,
    output logic        turn_left,
    output logic        turn_right,
    output logic [11:0] avg_y,
    output logic [11:0] avg_x,
    output logic        adc_timeout,
    output logic        frame_overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);

    joy_state_e           state_q;
    logic                 pending_q, cmd_valid_q, dir_valid_q, adc_to_q, ovr_q;
    logic [4:0]           cmd_ch_q;
    logic [AVG_LOG2-1:0]  cnt_q;
    logic [TW-1:0]        tmo_q;

    logic start, last, expire, y_hit, x_hit, y_tmo, x_tmo;
    logic mute;
    logic [11:0] hi_y, lo_y, hi_x, lo_x;
    dir_t dir_w;

    always_comb begin
        start  = (state_q == IDLE) && (new_frame || pending_q);
        last   = &cnt_q;
        expire = (tmo_q == TW'(TIMEOUT - 1));
        y_hit  = (state_q == WAIT_Y) && rsp_valid && (rsp_channel == JOY_CH_Y);
        x_hit  = (state_q == WAIT_X) && rsp_valid && (rsp_channel == JOY_CH_X);
        y_tmo  = (state_q == WAIT_Y) && !y_hit && expire;
        x_tmo  = (state_q == WAIT_X) && !x_hit && expire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_ch_q    <= '0;
            dir_valid_q <= 1'b0;
            adc_to_q    <= 1'b0;
            ovr_q       <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= '0;
        end else begin
            if (new_frame && state_q != IDLE) begin
                pending_q <= 1'b1;
                ovr_q     <= 1'b1;
            end
            case (state_q)
                IDLE: if (start) begin
                    pending_q   <= 1'b0;
                    cnt_q       <= '0;
                    cmd_valid_q <= 1'b1;
                    cmd_ch_q    <= JOY_CH_Y;
                    state_q     <= REQ_Y;
                end
                REQ_Y: if (cmd_ready) begin
                    cmd_valid_q <= 1'b0;
                    tmo_q       <= '0;
                    state_q     <= WAIT_Y;
                end
                WAIT_Y: begin
                    if ((y_hit && last) || y_tmo) begin
                        if (y_tmo)
                            adc_to_q <= 1'b1;
                        cnt_q       <= '0;
                        cmd_valid_q <= 1'b1;
                        cmd_ch_q    <= JOY_CH_X;
                        state_q     <= REQ_X;
                    end else if (y_hit) begin
                        cnt_q       <= cnt_q + 1'b1;
                        cmd_valid_q <= 1'b1;
                        state_q     <= REQ_Y;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                REQ_X: if (cmd_ready) begin
                    cmd_valid_q <= 1'b0;
                    tmo_q       <= '0;
                    state_q     <= WAIT_X;
                end
                WAIT_X: begin
                    if ((x_hit && last) || x_tmo) begin
                        if (x_tmo)
                            adc_to_q <= 1'b1;
                        dir_valid_q <= 1'b1;
                        state_q     <= PUBLISH;
                    end else if (x_hit) begin
                        cnt_q       <= cnt_q + 1'b1;
                        cmd_valid_q <= 1'b1;
                        state_q     <= REQ_X;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                PUBLISH: if (dir_ready) begin
                    dir_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef JOY_CENTER_CAL_EN
    logic        cal_done_q;
    logic [11:0] ctr_y_q, ctr_x_q;

    // The first published frame after reset captures the resting stick position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cal_done_q <= 1'b0;
            ctr_y_q    <= '0;
            ctr_x_q    <= '0;
        end else if (state_q == PUBLISH && dir_ready && !cal_done_q) begin
            cal_done_q <= 1'b1;
            ctr_y_q    <= avg_y;
            ctr_x_q    <= avg_x;
        end
    end

    assign mute = !cal_done_q;
    assign hi_y = sat12(int'(ctr_y_q) + HI_THRESH - 2048);
    assign lo_y = sat12(int'(ctr_y_q) - (2048 - LO_THRESH));
    assign hi_x = sat12(int'(ctr_x_q) + HI_THRESH - 2048);
    assign lo_x = sat12(int'(ctr_x_q) - (2048 - LO_THRESH));
`else
    assign mute = 1'b0;
    assign hi_y = 12'(HI_THRESH);
    assign lo_y = 12'(LO_THRESH);
    assign hi_x = 12'(HI_THRESH);
    assign lo_x = 12'(LO_THRESH);
`endif

    joy_axis_filter #(.AVG_LOG2(AVG_LOG2), .HYST(HYST)) u_y (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr_i    (start),
        .add_i    (y_hit),
        .last_i   (last),
        .tmo_i    (y_tmo),
        .mute_i   (mute),
        .data_i   (rsp_data),
        .hi_thr_i (hi_y),
        .lo_thr_i (lo_y),
        .avg_o    (avg_y),
        .hi_o     (dir_w.fwd),
        .lo_o     (dir_w.back)
    );

    joy_axis_filter #(.AVG_LOG2(AVG_LOG2), .HYST(HYST)) u_x (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr_i    (start),
        .add_i    (x_hit),
        .last_i   (last),
        .tmo_i    (x_tmo),
        .mute_i   (mute),
        .data_i   (rsp_data),
        .hi_thr_i (hi_x),
        .lo_thr_i (lo_x),
        .avg_o    (avg_x),
        .hi_o     (dir_w.left),
        .lo_o     (dir_w.right)
    );

    assign cmd_valid     = cmd_valid_q;
    assign cmd_channel   = cmd_ch_q;
    assign dir_valid     = dir_valid_q;
    assign move_fwd      = dir_w.fwd;
    assign move_back     = dir_w.back;
    assign turn_left     = dir_w.left;
    assign turn_right    = dir_w.right;
    assign adc_timeout   = adc_to_q;
    assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_joystick_sampler.sv
// Directed bench for joystick_sampler: ADC responder, frame-level reference model and
// a per-cycle compare of every published direction word.
module tb_joystick_sampler;

    localparam int HI = 2000;
    localparam int LO = 700;
    localparam int HY = 64;

    logic        clk = 1'b0, reset_n = 1'b0, new_frame = 1'b0;
    logic        cmd_valid, cmd_ready = 1'b0;
    logic [4:0]  cmd_channel, rsp_channel = 5'd0;
    logic        rsp_valid = 1'b0;
    logic [11:0] rsp_data = 12'd0;
    logic        dir_valid, dir_ready = 1'b0;
    logic        move_fwd, move_back, turn_left, turn_right;
    logic [11:0] avg_y, avg_x;
    logic        adc_timeout, frame_overrun;

    always #5 clk = ~clk;

    joystick_sampler #(.AVG_LOG2(2), .HI_THRESH(HI), .LO_THRESH(LO), .HYST(HY), .TIMEOUT(4096)) dut (
        .clk(clk), .reset_n(reset_n), .new_frame(new_frame),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .dir_valid(dir_valid), .dir_ready(dir_ready),
        .move_fwd(move_fwd), .move_back(move_back), .turn_left(turn_left), .turn_right(turn_right),
        .avg_y(avg_y), .avg_x(avg_x), .adc_timeout(adc_timeout), .frame_overrun(frame_overrun)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string nm, input int act, input int want);
        chk_cnt++;
        if (act == want) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, want);
    endtask

    // ADC responder: one outstanding command, response rsp_dly cycles after acceptance.
    int qy[$], qx[$];
    int out_ch = 0, dly = 0, cyc = 0, rsp_dly = 2;
    bit inj = 1'b0, drop_x = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        rsp_valid = 1'b0;
        if (!reset_n) begin
            out_ch = 0;
            qy.delete();
            qx.delete();
            cmd_ready = 1'b0;
        end else begin
            if (out_ch == 2 && drop_x) out_ch = 0;
            if (out_ch != 0) begin
                if (dly == 0) begin
                    rsp_valid   = 1'b1;
                    rsp_channel = 5'(out_ch);
                    if (out_ch == 1) rsp_data = (qy.size() > 0) ? 12'(qy.pop_front()) : 12'd0;
                    else             rsp_data = (qx.size() > 0) ? 12'(qx.pop_front()) : 12'd0;
                    out_ch = 0;
                end else begin
                    if (inj && out_ch == 1 && dly == 1) begin
                        rsp_valid   = 1'b1;
                        rsp_channel = 5'd2;
                        rsp_data    = 12'hFFF;
                        inj         = 1'b0;
                    end
                    dly--;
                end
            end
            cmd_ready = (cyc % 3 != 0);
            if (cmd_valid && cmd_ready && out_ch == 0) begin
                out_ch = int'(cmd_channel);
                dly    = rsp_dly;
            end
        end
    end

    // Frame-level reference: average of pushed samples, then threshold/hysteresis rules.
    typedef struct {
        bit f, b, l, r;
        int ay, ax;
    } exp_t;
    exp_t exq[$];
    bit mf = 0, mb = 0, ml = 0, mr = 0;
    int may = 0, max_ = 0;

    function automatic void hyst(input int a, input bit h0, input bit l0, output bit h1, output bit l1);
        h1 = h0 ? !(a < HI - HY) : (a > HI);
        l1 = l0 ? !(a > LO + HY) : (a < LO);
        if (h1 && l1) l1 = 1'b0;
    endfunction

    task automatic prep_frame(input int y0, input int y1, input int y2, input int y3,
                              input int xv, input bit xto);
        exp_t e;
        bit h, l;
        qy.push_back(y0); qy.push_back(y1); qy.push_back(y2); qy.push_back(y3);
        may = (y0 + y1 + y2 + y3) / 4;
        hyst(may, mf, mb, h, l);
        mf = h; mb = l;
        if (xto) begin
            ml = 1'b0; mr = 1'b0;
        end else begin
            repeat (4) qx.push_back(xv);
            max_ = xv;
            hyst(max_, ml, mr, h, l);
            ml = h; mr = l;
        end
        e.f = mf; e.b = mb; e.l = ml; e.r = mr; e.ay = may; e.ax = max_;
        exq.push_back(e);
    endtask

    initial forever begin
        @(negedge clk);
        if (reset_n && dir_valid) begin
            if (exq.size() == 0) chk("dir_unexpected", int'(dir_valid), 0);
            else begin
                chk("dir_word", int'({move_fwd, move_back, turn_left, turn_right}),
                    int'({exq[0].f, exq[0].b, exq[0].l, exq[0].r}));
                chk("dir_avg_y", int'(avg_y), exq[0].ay);
                chk("dir_avg_x", int'(avg_x), exq[0].ax);
                if (dir_ready) void'(exq.pop_front());
            end
        end
    end

    task automatic pulse_nf();
        @(posedge clk); #1 new_frame = 1'b1;
        @(posedge clk); #1 new_frame = 1'b0;
    endtask

    task automatic wait_dir(input string nm, input int budget);
        int n = 0;
        @(negedge clk);
        while (!dir_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(dir_valid), 1);
    endtask

    task automatic accept();
        repeat (3) @(negedge clk);
        chk("dir_valid_held", int'(dir_valid), 1);
        @(posedge clk); #1 dir_ready = 1'b1;
        @(posedge clk); #1 dir_ready = 1'b0;
        @(negedge clk);
        chk("dir_valid_drop", int'(dir_valid), 0);
    endtask

    task automatic wait_out_ch(input string nm, input int ch);
        int n = 0;
        while (out_ch != ch && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(nm, out_ch, ch);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd_channel", int'(cmd_channel), 0);
        chk("rst_dir_valid", int'(dir_valid), 0);
        chk("rst_flags", int'({move_fwd, move_back, turn_left, turn_right}), 0);
        chk("rst_avg", int'({avg_y, avg_x}), 0);
        chk("rst_sticky", int'({adc_timeout, frame_overrun}), 0);
        reset_n = 1'b1;

        prep_frame(2100, 2100, 2100, 2100, 1350, 0);
        pulse_nf();
        @(negedge clk);
        chk("f1_cmd_valid", int'(cmd_valid), 1);
        chk("f1_cmd_channel", int'(cmd_channel), 1);
        wait_dir("f1_dir", 300);
        chk("f1_avg_y", int'(avg_y), 2100);
        chk("f1_avg_x", int'(avg_x), 1350);
        chk("f1_fwd", int'(move_fwd), 1);
        chk("f1_others", int'({move_back, turn_left, turn_right}), 0);
        accept();

        prep_frame(1960, 1960, 1960, 1960, 1350, 0);
        pulse_nf();
        wait_dir("f2_dir", 300);
        chk("f2_fwd_hyst_hold", int'(move_fwd), 1);
        accept();

        prep_frame(1930, 1930, 1930, 1930, 1350, 0);
        pulse_nf();
        wait_dir("f3_dir", 300);
        chk("f3_fwd_clear", int'(move_fwd), 0);
        accept();

        inj = 1'b1;
        prep_frame(2001, 2001, 2001, 2002, 600, 0);
        pulse_nf();
        wait_dir("f4_dir", 300);
        chk("f4_inj_used", int'(inj), 0);
        chk("f4_avg_y_trunc", int'(avg_y), 2001);
        chk("f4_fwd_right", int'({move_fwd, move_back, turn_left, turn_right}), 4'b1001);
        accept();

        prep_frame(500, 500, 500, 500, 760, 0);
        pulse_nf();
        wait_dir("f5_dir", 300);
        chk("f5_back_right", int'({move_fwd, move_back, turn_left, turn_right}), 4'b0101);
        chk("f5_no_timeout", int'(adc_timeout), 0);
        accept();

        drop_x = 1'b1;
        prep_frame(1000, 1000, 1000, 1000, 0, 1);
        pulse_nf();
        wait_dir("f6_dir", 9000);
        chk("f6_timeout", int'(adc_timeout), 1);
        chk("f6_x_flags", int'({turn_left, turn_right}), 0);
        chk("f6_avg_x_kept", int'(avg_x), 760);
        accept();
        drop_x = 1'b0;

        rsp_dly = 6;
        prep_frame(2100, 2100, 2100, 2100, 2100, 0);
        pulse_nf();
        wait_out_ch("f7_y_cmd", 1);
        @(posedge clk); #1 new_frame = 1'b1;
        @(posedge clk); #1 new_frame = 1'b0;
        @(posedge clk); #1 new_frame = 1'b1;
        @(posedge clk); #1 new_frame = 1'b0;
        rsp_dly = 2;
        chk("f7_overrun", int'(frame_overrun), 1);
        prep_frame(300, 300, 300, 300, 300, 0);
        wait_dir("f7_dir", 300);
        accept();
        wait_dir("f8_dir", 300);
        chk("f8_back_right", int'({move_fwd, move_back, turn_left, turn_right}), 4'b0101);
        accept();
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (cmd_valid) seen++;
        end
        chk("no_third_frame", seen, 0);
        chk("model_drained", exq.size(), 0);

        qy.push_back(2100); qy.push_back(2100); qy.push_back(2100); qy.push_back(2100);
        repeat (4) qx.push_back(1350);
        pulse_nf();
        wait_out_ch("rst_x_cmd", 2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_cmd", int'({cmd_valid, cmd_channel}), 0);
        chk("mid_rst_dir", int'({dir_valid, move_fwd, move_back, turn_left, turn_right}), 0);
        chk("mid_rst_avg", int'({avg_y, avg_x}), 0);
        chk("mid_rst_sticky", int'({adc_timeout, frame_overrun}), 0);
        mf = 0; mb = 0; ml = 0; mr = 0; may = 0; max_ = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        prep_frame(2100, 2100, 2100, 2100, 1350, 0);
        pulse_nf();
        @(negedge clk);
        chk("f9_restart_y", int'({cmd_valid, cmd_channel}), int'({1'b1, 5'd1}));
        wait_dir("f9_dir", 300);
        chk("f9_fwd", int'({move_fwd, move_back, turn_left, turn_right}), 4'b1000);
        accept();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/joystick_sampler.md
Name: joystick_sampler

Overview:
- Upstream stage of playermovement.
- Owns the modular ADC command/response stream. Once per frame it samples the Y stick (channel 1) and the X stick (channel 2), averages 2^AVG_LOG2 samples per axis, and applies thresholds with hysteresis.
- Publishes one registered direction word (fwd/back/left/right) per frame over a valid/ready handshake. Movement logic consumes only clean, frame-aligned commands and never sees raw ADC traffic.

Parameters:
- AVG_LOG2, 2, log2 of samples averaged per axis (1..4).
- HI_THRESH, 2000, 12-bit level above which fwd (Y) or left (X) asserts.
- LO_THRESH, 700, 12-bit level below which back (Y) or right (X) asserts.
- HYST, 64, hysteresis band; an asserted flag drops only once the average returns HYST inside its threshold.
- TIMEOUT, 4096, max clk cycles waiting for one ADC response.

Ports:
- clk  in  1  system clock (ADC sys clock domain)
- reset_n  in  1  asynchronous, active-low reset
- new_frame  in  1  single-cycle frame strobe
- cmd_valid  out  1  ADC command valid
- cmd_channel  out  5  ADC command channel
- cmd_ready  in  1  ADC command accepted
- rsp_valid  in  1  ADC response valid
- rsp_channel  in  5  ADC response channel
- rsp_data  in  12  ADC sample
- dir_valid  out  1  direction word available
- dir_ready  in  1  consumer accepts direction word
- move_fwd, move_back, turn_left, turn_right  out  1 each  direction flags, stable while dir_valid
- avg_y, avg_x  out  12 each  last averaged samples
- adc_timeout  out  1  sticky; a response wait expired
- frame_overrun  out  1  sticky; new_frame arrived while busy

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; every output, accumulator, hysteresis flag and pending bit is 0; cmd_channel = 0.
- FSM states: IDLE, REQ_Y, WAIT_Y, REQ_X, WAIT_X, PUBLISH.
- IDLE: on new_frame, or a pending bit already set, clear pending, clear the sample counter and accumulator, go to REQ_Y.
- REQ_*: cmd_valid = 1, cmd_channel = 1 for Y or 2 for X. Hold both until cmd_ready, then go to WAIT_*. At most one command is outstanding.
- WAIT_*: rsp_valid with a matching channel adds zero-extended rsp_data to a (12+AVG_LOG2)-bit accumulator and increments the counter.
  - If samples remain, return to REQ_*.
  - Otherwise average = accumulator >> AVG_LOG2 (truncating), registered into avg_*, and the hysteresis update runs on the same edge.
  - Y completion goes to REQ_X; X completion goes to PUBLISH.
- Responses with a non-matching channel, or arriving outside WAIT_*, are discarded.
- Timeout: a per-wait cycle counter reaching TIMEOUT sets adc_timeout. That axis's flags are forced to 0, avg_* keeps its old value, and the FSM advances as if the axis had completed.
- Hysteresis, Y axis (X is identical with left/right):
  - fwd sets when avg > HI_THRESH; fwd clears when avg < HI_THRESH-HYST.
  - back sets when avg < LO_THRESH; back clears when avg > LO_THRESH+HYST.
  - fwd and back are never both 1; if both set conditions hold, fwd wins.
- PUBLISH: dir_valid = 1 with flags frozen. On the dir_valid && dir_ready edge, drop dir_valid and go to IDLE. dir_valid is never withdrawn before acceptance.
- Latency: at least 2*2^AVG_LOG2 command/response round trips plus 2 cycles from new_frame to dir_valid.
- new_frame outside IDLE sets pending (saturating, one deep) and frame_overrun.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: JOY_CENTER_CAL_EN.
- Defined:
  - The first complete averages after reset are stored as center_y and center_x. That frame publishes all-zero flags.
  - Thresholds then become center+(HI_THRESH-2048) and center-(2048-LO_THRESH), saturated to 0..4095.
- Undefined: fixed HI_THRESH/LO_THRESH and no calibration frame.

Decomposition:
- Package joy_pkg holds:
  - dir_t packed struct {fwd, back, left, right}
  - localparams JOY_CH_Y=5'd1, JOY_CH_X=5'd2
  - FSM state enum
- Sub-module joy_axis_filter: accumulator, averaging and hysteresis for one axis. Instantiated twice; the top keeps the FSM and ADC handshake.

Test Plan:
- AVG_LOG2=2; Y samples 2100,2100,2100,2100 and X all 1350; new_frame -> avg_y=2100, move_fwd=1, other flags 0, dir_valid held until dir_ready.
- Next frame Y averages 1960 -> move_fwd stays 1 (inside hysteresis). Following frame Y averages 1930 -> move_fwd=0.
- ADC model drives rsp_channel=2 during WAIT_Y -> sample ignored; accumulator and counter unchanged.
- ADC model never responds on X -> after 4096 cycles adc_timeout=1, left/right=0, dir_valid still asserts.
- Two new_frame pulses during WAIT_Y -> frame_overrun=1; exactly one extra frame runs after the PUBLISH handshake.
- Assert reset_n low mid-WAIT_X -> all outputs 0 immediately; next new_frame restarts at REQ_Y with cmd_channel=1.
